// File: rtl/coloring_pkg.sv
// Shared definitions for the colour-sequence generator and checker.
// Provides colour constants, the generator state encoding, the LFSR taps,
// and the rule-aware colour selection helper.
package coloring_pkg;

    localparam int unsigned COL_W = 2;

    localparam logic [COL_W-1:0] COL0     = 2'd0;
    localparam logic [COL_W-1:0] COL1     = 2'd1;
    localparam logic [COL_W-1:0] COL2     = 2'd2;
    localparam logic [COL_W-1:0] COL_TERM = 2'd3;

    // Feedback taps for the 8-bit Fibonacci LFSR: bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TERM = 2'd2
    } gen_state_t;

    // Take the LFSR candidate when it keeps the sequence legal. Otherwise
    // fall back to 2, or, when 2 has already repeated twice, to 0/1 chosen
    // by lfsr bit 2. Either fallback is always legal after the previous colour.
    function automatic logic [COL_W-1:0] choose_colour(
        input logic [7:0]       l,
        input logic [COL_W-1:0] prev,
        input logic [1:0]       run
    );
        logic [COL_W-1:0] cand;
        logic             bad;
        cand = l[1:0];
        bad  = (cand == COL_TERM)
             | (!prev[1] && !cand[1] && (cand != prev))
             | ((cand == prev) && (run == 2'd2));
        if (!bad)
            return cand;
        else if ((prev == COL2) && (run == 2'd2))
            return {1'b0, l[2]};
        else
            return COL2;
    endfunction

endpackage

// File: rtl/coloring_lfsr8.sv
// 8-bit Fibonacci LFSR for stimulus generators.
// Ports: clk, rst (sync, active-high, resets to 8'h01), load (takes seed,
// with 8'h00 replaced by 8'h01), enable (advance one step), seed, value.
module coloring_lfsr8
    import coloring_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic fb;

    assign fb = ^(value & LFSR_TAPS);

    // Load has priority over advance; the all-zero state is never entered.
    always_ff @(posedge clk) begin
        if (rst)
            value <= 8'h01;
        else if (load)
            value <= (seed == 8'h00) ? 8'h01 : seed;
        else if (enable)
            value <= {value[6:0], fb};
    end

endmodule

// File: rtl/coloring_gen.sv
// Generates a legal pseudo-random colour stream (0/1/2) of length len,
// followed by one terminator colour 3, over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), start/len/seed (request, taken in
// IDLE), out_valid/out_ready/out_color/out_last (stream), busy (RUN or
// TERM), done (one-cycle pulse after the terminator is accepted).
module coloring_gen
    import coloring_pkg::*;
#(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned LFSR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_color,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    if (LFSR_W != 8) begin : g_bad_lfsr_w
        $error("coloring_gen: only LFSR_W == 8 is supported");
    end

    gen_state_t       state;
    logic [LEN_W-1:0] count;
    logic [1:0]       prev;
    logic [1:0]       run;
    logic [7:0]       lfsr;
    logic [1:0]       colour_c;
    logic             fire;
    logic             lfsr_load;
    logic             lfsr_en;

    assign fire      = out_valid & out_ready;
    assign lfsr_load = (state == ST_IDLE) & start;
    assign lfsr_en   = (state == ST_RUN) & fire;

    coloring_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (seed),
        .value  (lfsr)
    );

    // Colour for the current RUN beat, decoded from registered state only.
    always_comb begin
        colour_c = choose_colour(lfsr, prev, run);
    end

    // Stream outputs are straight decodes of the state register.
    assign out_valid = (state != ST_IDLE);
    assign out_last  = (state == ST_TERM);
    assign busy      = (state != ST_IDLE);
    assign out_color = (state == ST_TERM) ? COL_TERM :
                       (state == ST_RUN)  ? colour_c : COL0;

    // Sequencer: length counter, colour history and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            prev  <= COL_TERM;
            run   <= 2'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count <= len;
                        prev  <= COL_TERM;
                        run   <= 2'd0;
                        state <= (len == '0) ? ST_TERM : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        run   <= (colour_c == prev) ? run + 2'd1 : 2'd1;
                        prev  <= colour_c;
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1))
                            state <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (fire) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        prev  <= COL_TERM;
                        run   <= 2'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coloring_gen.sv
// Directed and randomised checks of coloring_gen against hand-computed
// sequences and an independent colouring-rule checker.
module tb_coloring_gen;

    typedef logic [1:0] col_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] seed = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_color;
    logic       out_last;
    logic       busy;
    logic       done;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    coloring_gen #(.LEN_W(8), .LFSR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_color (out_color),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input logic [7:0] s, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        len   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_last"},  int'(out_last), 0);
    endtask

    // Walk the beats of a running sequence, with an optional stall and an
    // optional ignored start pulse, then the terminator and done pulse.
    task automatic expect_beats(input string tag, input col_q_t exp,
                                input int stall_beat, input int stall_n,
                                input int poke_beat);
        for (int i = 0; i < exp.size(); i++) begin
            if (i == stall_beat) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check($sformatf("%s_stall_valid%0d", tag, k), int'(out_valid), 1);
                    check($sformatf("%s_stall_color%0d", tag, k), int'(out_color), int'(exp[i]));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            if (i == poke_beat) begin
                start = 1'b1;
                seed  = 8'h55;
                len   = 8'd3;
            end
            check($sformatf("%s_color%0d", tag, i), int'(out_color), int'(exp[i]));
            check($sformatf("%s_beat%0d", tag, i),
                  int'({out_valid, out_last, busy}), int'(3'b101));
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_term_color"}, int'(out_color), 3);
        check({tag, "_term_flags"}, int'({out_valid, out_last, busy}), int'(3'b111));
        @(negedge clk);
        check({tag, "_done"}, int'(done), 1);
        check_idle({tag, "_after"});
        @(negedge clk);
        check({tag, "_done_clear"}, int'(done), 0);
    endtask

    col_q_t seq6;
    int     prev_c, run_c, beats, terms, bad, cyc, c;
    bit     fin;

    initial begin
        // seed 1: lfsr 01,02,04,08,11,23 -> cand 1,2,0,0,1(illegal after 0),3(illegal)
        seq6 = {2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};

        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_color", int'(out_color), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;

        start_seq(8'h01, 8'd6);
        expect_beats("basic", seq6, -1, 0, -1);

        start_seq(8'h01, 8'd6);
        expect_beats("stall", seq6, 2, 3, -1);

        start_seq(8'h00, 8'd0);
        check("len0_color", int'(out_color), 3);
        check("len0_flags", int'({out_valid, out_last, busy}), int'(3'b111));
        @(negedge clk);
        check("len0_done", int'(done), 1);
        check_idle("len0_after");

        start_seq(8'h00, 8'd6);
        expect_beats("seed0", seq6, -1, 0, -1);

        start_seq(8'h01, 8'd6);
        expect_beats("poke", seq6, -1, 0, 2);

        // Abort during beat 4 of a len=10 run.
        start_seq(8'h01, 8'd10);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_color%0d", i), int'(out_color), int'(seq6[i]));
            @(negedge clk);
        end
        check("abort_beat4", int'(out_color), 0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        start_seq(8'h01, 8'd6);
        expect_beats("post_abort", seq6, -1, 0, -1);

        // Random seeds, full length, random back-pressure, rule checker.
        for (int r = 0; r < 200; r++) begin
            start_seq(8'($urandom_range(0, 255)), 8'd255);
            prev_c = 3; run_c = 0; beats = 0; terms = 0; bad = 0; cyc = 0; fin = 1'b0;
            while (!fin && cyc < 3000) begin
                out_ready = ($urandom_range(0, 7) != 0);
                if (out_valid && out_ready) begin
                    c = int'(out_color);
                    if (out_last) begin
                        terms++;
                        if (c != 3) bad++;
                        fin = 1'b1;
                    end else begin
                        if (c == 3) bad++;
                        if (prev_c < 2 && c < 2 && c != prev_c) bad++;
                        if (c == prev_c && run_c == 2) bad++;
                        run_c  = (c == prev_c) ? run_c + 1 : 1;
                        prev_c = c;
                        beats++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            check($sformatf("rand%0d_finished", r), int'(fin), 1);
            check($sformatf("rand%0d_rules", r), bad, 0);
            check($sformatf("rand%0d_beats", r), beats, 255);
            check($sformatf("rand%0d_terms", r), terms, 1);
            check($sformatf("rand%0d_done", r), int'(done), 1);
        end
        out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
